// File: rtl/divcnt_sched.sv
// divcnt_sched: grants one shared prescaler counter to NREQ requesters and counts divided ticks.
// Define DIVSCHED_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
`default_nettype none

module divcnt_sched #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 7,
  parameter int LEN_W = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DIV_W-1:0]        cfg_div_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*LEN_W-1:0]   len_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    tick_o,
  output logic                    busy_o,
  output logic [DIV_W-1:0]        divcnt_o
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   divcnt_q;
  logic [LEN_W-1:0]   rem_q;
  logic [IDX_W-1:0]   win_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    done_q;

  logic [IDX_W-1:0]   win_d;
  logic [LEN_W-1:0]   len_win;
  logic               tick;
  logic               abort;

`ifdef DIVSCHED_RR_EN
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;

  // Scan downward so the last hit is the first set bit at or after ptr.
  always_comb begin
    int idx;
    win_d = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[idx]) win_d = IDX_W'(idx);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_DONE || abort) begin
      ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_d = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[k]) win_d = IDX_W'(k);
    end
  end
`endif

  assign len_win = len_i[win_d*LEN_W +: LEN_W];
  // A zero-length slice never ticks, even with a divide ratio of 0.
  assign tick    = (state_q == S_RUN) && (rem_q != '0) && (divcnt_q == div_q);
  assign abort   = (state_q == S_RUN) && !req_i[win_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      divcnt_q <= '0;
      rem_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          divcnt_q <= '0;
          done_q   <= '0;
          if (|req_i) begin
            state_q <= S_RUN;
            win_q   <= win_d;
            gnt_q   <= NREQ'(1) << win_d;
            div_q   <= cfg_div_i;
            rem_q   <= len_win;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            divcnt_q <= '0;
          end else begin
            if (tick) begin
              divcnt_q <= '0;
              rem_q    <= rem_q - 1'b1;
            end else begin
              divcnt_q <= divcnt_q + 1'b1;
            end
            if ((rem_q == '0) || ((rem_q == LEN_W'(1)) && tick)) begin
              state_q  <= S_DONE;
              gnt_q    <= '0;
              done_q   <= NREQ'(1) << win_q;
              divcnt_q <= '0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
        end
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign tick_o   = tick;
  assign busy_o   = (state_q == S_RUN) || (state_q == S_DONE);
  assign divcnt_o = divcnt_q;

endmodule

`default_nettype wire

// File: doc/divcnt_sched.md
# divcnt_sched

Time-slice scheduler that shares a single divided-clock counter among NREQ requesters. The block grants the counter to one requester at a time and programs its divide ratio. It then counts the requested number of divided ticks and signals completion. It sits between client blocks that need timed waits and the shared prescaler counter.

## Interface
- NREQ, 4, number of requesters (2..8)
- DIV_W, 7, prescaler counter width
- LEN_W, 7, per-request tick-count width

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_div  in  DIV_W  prescale terminal count; one tick every cfg_div+1 clocks; sampled at grant
- req  in  NREQ  level request per requester; held until done or dropped to abort
- len  in  NREQ*LEN_W  tick count per requester, slice i = len[i*LEN_W +: LEN_W]; sampled at grant
- gnt  out  NREQ  one-hot grant; high for the whole RUN state
- done  out  NREQ  one-hot single-cycle completion pulse
- tick  out  1  divided tick pulse for the active requester
- busy  out  1  high in RUN or DONE
- divcnt  out  DIV_W  current prescaler value

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Registers: div_q, remaining (LEN_W), winner index, priority pointer ptr.
- IDLE: divcnt held at 0. If any req bit is set, the arbiter picks a winner at the clock edge. The same edge loads gnt[winner]=1, div_q=cfg_div, remaining=len[winner], divcnt=0, and sets state=RUN.
- RUN: tick = (divcnt==div_q), combinational from registers.
  - On tick: divcnt<=0 and remaining<=remaining-1. Otherwise divcnt<=divcnt+1.
  - If remaining==1 and tick, or remaining==0: next state is DONE.
  - If req[winner] falls: abort. Next state is IDLE, gnt clears, no done pulse, ptr updates as on completion.
- DONE: gnt=0 and done[winner]=1 for exactly one cycle. ptr<=(winner+1) mod NREQ. Next state is IDLE.
- The requester drops req in the done cycle or later. A req still high in IDLE is a new request.
- cfg_div and len changes during RUN are ignored, because both are latched at grant.
- divcnt never exceeds div_q, so no wrap beyond the terminal count. remaining never underflows.
- Reset values: gnt=0, done=0, tick=0, busy=0, divcnt=0, ptr=0, remaining=0, div_q=0.

## Timing
- Grant latency: req sampled high in IDLE at edge k, gnt high after edge k.
- With D=div_q and L=len ≥ 1: ticks fall in RUN cycles D+1, 2(D+1), …, L(D+1). gnt is high for exactly L(D+1) cycles.
- done pulses in the cycle after the last gnt cycle. IDLE lasts at least one cycle.
- Back-to-back grant period is L(D+1)+2 cycles.
- len=0: gnt is high for 1 cycle with no tick, then done.
- D=0: tick is high every RUN cycle.
- Abort: gnt is low in the cycle after req falls. The earliest next grant is one cycle later.
- Reset asserted mid-RUN: all outputs reach reset values immediately, and the state is IDLE when reset releases.

## Configuration
- DIVSCHED_RR_EN defined: round-robin arbitration. The search starts at ptr and takes the first set req bit in increasing index, mod NREQ.
- Not defined: fixed priority, lowest index wins. ptr is unused and is optimised away.

## Test plan
- D=3, L=2, req=4'b0010 held: gnt=4'b0010 for 8 cycles, tick in RUN cycles 4 and 8, done=4'b0010 in cycle 9, busy low in cycle 10.
- DIVSCHED_RR_EN defined, req=4'b1111 held, L=1, D=0: grant order 0,1,2,3,0, each gnt 1 cycle, period 3 cycles. Without the macro: order 0,0,0.
- len=0, D=5: gnt high 1 cycle, tick never asserted, done the next cycle.
- D=2, L=4, req dropped in RUN cycle 5: gnt low in cycle 6, no done pulse, state IDLE.
- cfg_div changed from 3 to 1 mid-RUN with L=2: tick spacing stays at 4 cycles. The next grant uses a spacing of 2.
- reset low in RUN cycle 3 for 1 cycle: gnt, tick, busy and divcnt are 0 immediately. After release with req held, grant follows in 1 cycle, and under RR the grant goes to the lowest set index because ptr is 0.
